// File: rtl/test_engine_nic_input_queue.sv
// ============================================================================
// Module   : test_engine_nic_input_queue
// Purpose  : Packet-buffering input queue between a NoC router and a PE.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module test_engine_nic_input_queue #(
  parameter int CHANNEL_WIDTH = 32,
  parameter int DATA_FLITS    = 4,
  parameter int PACKET_SLOTS  = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [CHANNEL_WIDTH-1:0]            input_channel_din,
  input  logic                                busy_engine_din,
  input  logic                                zero_credits_din,
  output logic [DATA_FLITS*CHANNEL_WIDTH-1:0] data_flits_dout,
  output logic [CHANNEL_WIDTH-3:0]            header_flit_dout,
  output logic                                transfer2pe_strobe_dout,
  output logic                                credit_return_dout,
  output logic [$clog2(PACKET_SLOTS):0]       occupancy_dout,
  output logic                                overflow_error_dout
);

  localparam int c_PTR_W  = $clog2(PACKET_SLOTS);
  localparam int c_OCC_W  = c_PTR_W + 1;
  localparam int c_CNT_W  = (DATA_FLITS > 1) ? $clog2(DATA_FLITS) : 1;
  localparam int c_HDR_W  = CHANNEL_WIDTH - 2;
  localparam int c_DATA_W = DATA_FLITS * CHANNEL_WIDTH;

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_FLITS - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [c_OCC_W-1:0] c_OCC_ONE  = c_OCC_W'(1);
  localparam logic [c_OCC_W-1:0] c_OCC_FULL = c_OCC_W'(PACKET_SLOTS);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    drop_q, drop_d;
  logic [c_CNT_W-1:0]      cnt_q, cnt_d;
  logic [c_PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [c_OCC_W-1:0]      occ_q, occ_d;
  logic [PACKET_SLOTS-1:0] valid_q, valid_d;
  logic                    strobe_q, strobe_d;
  logic                    credit_q, credit_d;
  logic                    ovf_q, ovf_d;
  logic [c_HDR_W-1:0]      hdr_out_q, hdr_out_d;
  logic [c_DATA_W-1:0]     data_out_q, data_out_d;

  logic [c_HDR_W-1:0]      slot_hdr_q  [PACKET_SLOTS];
  logic [c_DATA_W-1:0]     slot_data_q [PACKET_SLOTS];

  logic w_is_header;
  logic w_full;
  logic w_dispatch;
  logic w_hdr_we;
  logic w_data_we;
  logic w_complete;

  assign w_is_header = input_channel_din[CHANNEL_WIDTH-1];
  // Occupancy is authoritative; the valid bit guards against overwriting a live slot.
  assign w_full      = (occ_q == c_OCC_FULL) || valid_q[wr_ptr_q];
  assign w_dispatch  = (occ_q != '0) && !busy_engine_din && !zero_credits_din && !strobe_q;

  // Capture FSM: a dropped packet still walks through CAPTURE to consume its flits.
  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    ovf_d      = ovf_q;
    w_hdr_we   = 1'b0;
    w_data_we  = 1'b0;
    w_complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_is_header) begin
          state_d = CAPTURE;
          cnt_d   = '0;
          if (w_full) begin
            drop_d = 1'b1;
            ovf_d  = 1'b1;
          end else begin
            drop_d   = 1'b0;
            w_hdr_we = 1'b1;
          end
        end
      end
      CAPTURE: begin
        w_data_we = !drop_q;
        cnt_d     = cnt_q + c_CNT_ONE;
        if (cnt_q == c_CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!drop_q) begin
            w_complete = 1'b1;
            wr_ptr_d   = wr_ptr_q + c_PTR_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    occ_d      = occ_q;
    valid_d    = valid_q;
    rd_ptr_d   = rd_ptr_q;
    strobe_d   = w_dispatch;
    credit_d   = w_dispatch;
    hdr_out_d  = hdr_out_q;
    data_out_d = data_out_q;
    if (w_complete) begin
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (w_dispatch) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + c_PTR_ONE;
      hdr_out_d         = slot_hdr_q[rd_ptr_q];
      data_out_d        = slot_data_q[rd_ptr_q];
    end
    case ({w_complete, w_dispatch})
      2'b10:   occ_d = occ_q + c_OCC_ONE;
      2'b01:   occ_d = occ_q - c_OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      valid_q    <= '0;
      strobe_q   <= 1'b0;
      credit_q   <= 1'b0;
      ovf_q      <= 1'b0;
      hdr_out_q  <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
      credit_q   <= credit_d;
      ovf_q      <= ovf_d;
      hdr_out_q  <= hdr_out_d;
      data_out_q <= data_out_d;
    end
  end

  // Slot storage needs no reset: contents are only read once the valid bit is set.
  always_ff @(posedge clk) begin
    if (w_hdr_we) begin
      slot_hdr_q[wr_ptr_q] <= input_channel_din[c_HDR_W-1:0];
    end
    if (w_data_we) begin
      for (int f = 0; f < DATA_FLITS; f++) begin
        if (cnt_q == c_CNT_W'(f)) begin
          slot_data_q[wr_ptr_q][(DATA_FLITS-1-f)*CHANNEL_WIDTH +: CHANNEL_WIDTH] <= input_channel_din;
        end
      end
    end
  end

  assign data_flits_dout         = data_out_q;
  assign header_flit_dout        = hdr_out_q;
  assign transfer2pe_strobe_dout = strobe_q;
  assign credit_return_dout      = credit_q;
  assign occupancy_dout          = occ_q;
  assign overflow_error_dout     = ovf_q;

endmodule

`default_nettype wire
